// File: rtl/alu_req_sched_pkg.sv
// Shared types and defaults for the two-requester mini-ALU scheduler.
package alu_sched_pkg;

    localparam int IN_W        = 6;
    localparam int OUT_W       = 8;
    localparam int OP_W        = 3;
    localparam int TIMEOUT_DEF = 15;
    localparam int CNT_W       = 4;

    localparam logic [OUT_W-1:0] TIMEOUT_DATA = 8'hFF;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } sched_state_e;

endpackage

// File: rtl/alu_req_sched_if.sv
// Request, ALU and response signals of the scheduler, bundled for port connection.
interface alu_req_sched_if;
    import alu_sched_pkg::*;

    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [IN_W-1:0]  req0_a;
    logic [IN_W-1:0]  req0_b;
    logic [OP_W-1:0]  req0_op;
    logic [IN_W-1:0]  req1_a;
    logic [IN_W-1:0]  req1_b;
    logic [OP_W-1:0]  req1_op;

    logic [OUT_W-1:0] alu_a;
    logic [OUT_W-1:0] alu_b;
    logic [OP_W-1:0]  alu_op;
    logic             alu_start;
    logic             alu_done;
    logic [OUT_W-1:0] alu_result;

    logic             rsp_valid;
    logic             rsp_id;
    logic [OUT_W-1:0] rsp_data;
    logic             rsp_err;

    modport slave (
        input  req_valid, req0_a, req0_b, req0_op, req1_a, req1_b, req1_op,
        output req_ready,
        output alu_a, alu_b, alu_op, alu_start,
        input  alu_done, alu_result,
        output rsp_valid, rsp_id, rsp_data, rsp_err
    );

    modport master (
        output req_valid, req0_a, req0_b, req0_op, req1_a, req1_b, req1_op,
        input  req_ready,
        input  alu_a, alu_b, alu_op, alu_start,
        output alu_done, alu_result,
        input  rsp_valid, rsp_id, rsp_data, rsp_err
    );

endinterface

// File: rtl/alu_req_sched_arb.sv
// Two-way combinational grant. ALU_SCHED_RR_EN selects round-robin on the
// last-grant pointer; otherwise requester 0 has fixed priority.
module alu_req_arb (
    input  logic [1:0] req_valid_i,
    input  logic       last_grant_i,
    output logic [1:0] grant_o
);

    always_comb begin
        grant_o = 2'b00;
`ifdef ALU_SCHED_RR_EN
        if (req_valid_i == 2'b11) begin
            grant_o = last_grant_i ? 2'b01 : 2'b10;
        end else begin
            grant_o = req_valid_i;  // zero or one requester: no contention
        end
`else
        if (req_valid_i[0]) begin
            grant_o = 2'b01;
        end else if (req_valid_i[1]) begin
            grant_o = 2'b10;
        end
`endif
    end

`ifndef ALU_SCHED_RR_EN
    logic unused_last_grant;
    assign unused_last_grant = last_grant_i;
`endif

endmodule

// File: rtl/alu_req_sched.sv
// Arbitrates two operand requesters onto one 8-bit ALU, waits for completion
// with a timeout and returns a tagged response. Option macro: ALU_SCHED_RR_EN.
module alu_req_sched
    import alu_sched_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    alu_req_sched_if.slave bus
);

    localparam logic [CNT_W-1:0] TMO_LOAD = CNT_W'(TIMEOUT);

    sched_state_e     state_q, state_d;
    logic [OUT_W-1:0] alu_a_q, alu_a_d;
    logic [OUT_W-1:0] alu_b_q, alu_b_d;
    logic [OP_W-1:0]  alu_op_q, alu_op_d;
    logic             alu_start_q, alu_start_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_id_q, rsp_id_d;
    logic [OUT_W-1:0] rsp_data_q, rsp_data_d;
    logic             rsp_err_q, rsp_err_d;
    logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             last_grant;
    logic [1:0]       grant;
    logic [1:0]       ready;

`ifdef ALU_SCHED_RR_EN
    logic last_grant_q, last_grant_d;

    always_comb begin
        last_grant_d = last_grant_q;
        if (state_q == S_RESP) begin
            last_grant_d = rsp_id_q;
        end
    end

    // Reset to requester 1 so requester 0 wins the first contention.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

    assign last_grant = last_grant_q;
`else
    assign last_grant = 1'b1;
`endif

    alu_req_arb u_arb (
        .req_valid_i  (bus.req_valid),
        .last_grant_i (last_grant),
        .grant_o      (grant)
    );

    assign ready         = (state_q == S_IDLE) ? grant : 2'b00;
    assign bus.req_ready = ready;

    always_comb begin
        state_d     = state_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_op_d    = alu_op_q;
        alu_start_d = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        tmo_cnt_d   = tmo_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (ready[1]) begin
                    alu_a_d     = OUT_W'(bus.req1_a);
                    alu_b_d     = OUT_W'(bus.req1_b);
                    alu_op_d    = bus.req1_op;
                    rsp_id_d    = 1'b1;
                    alu_start_d = 1'b1;
                    state_d     = S_ISSUE;
                end else if (ready[0]) begin
                    alu_a_d     = OUT_W'(bus.req0_a);
                    alu_b_d     = OUT_W'(bus.req0_b);
                    alu_op_d    = bus.req0_op;
                    rsp_id_d    = 1'b0;
                    alu_start_d = 1'b1;
                    state_d     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                tmo_cnt_d = TMO_LOAD;
                state_d   = S_WAIT;
            end
            S_WAIT: begin
                // A done strobe on the terminal-count cycle still wins.
                if (bus.alu_done) begin
                    rsp_data_d  = bus.alu_result;
                    rsp_err_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = S_RESP;
                end else if (tmo_cnt_q == '0) begin
                    rsp_data_d  = TIMEOUT_DATA;
                    rsp_err_d   = 1'b1;
                    rsp_valid_d = 1'b1;
                    state_d     = S_RESP;
                end else begin
                    tmo_cnt_d = tmo_cnt_q - 1'b1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= '0;
            alu_start_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            tmo_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_op_q    <= alu_op_d;
            alu_start_q <= alu_start_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            tmo_cnt_q   <= tmo_cnt_d;
        end
    end

    assign bus.alu_a     = alu_a_q;
    assign bus.alu_b     = alu_b_q;
    assign bus.alu_op    = alu_op_q;
    assign bus.alu_start = alu_start_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_alu_req_sched.sv
// Directed bench for alu_req_sched: expected responses go into a scoreboard
// queue that a separate monitor drains whenever rsp_valid is seen.
module tb_alu_req_sched;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    alu_req_sched_if bus ();

    alu_req_sched dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       id;
        logic [7:0] data;
        logic       err;
    } rsp_t;

    rsp_t exp_q[$];
    int   n_chk = 0;
    int   n_err = 0;
    int   exp_order[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.rsp_valid) begin
            if (exp_q.size() == 0) begin
                chk("rsp_unexpected", 32'd1, 32'd0);
            end else begin
                rsp_t e;
                e = exp_q.pop_front();
                chk("rsp_id",   32'(bus.rsp_id),   32'(e.id));
                chk("rsp_data", 32'(bus.rsp_data), 32'(e.data));
                chk("rsp_err",  32'(bus.rsp_err),  32'(e.err));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int id, input logic [5:0] a, input logic [5:0] b, input logic [2:0] op);
        if (id == 0) begin
            bus.req0_a = a; bus.req0_b = b; bus.req0_op = op;
        end else begin
            bus.req1_a = a; bus.req1_b = b; bus.req1_op = op;
        end
        bus.req_valid[id] = 1'b1;
    endtask

    // Returns just after the accepting edge (scheduler in ISSUE).
    task automatic wait_accept(input int id);
        bit ok;
        int n;
        ok = 0;
        n  = 0;
        while (!ok && n < 40) begin
            @(negedge clk);
            n++;
            if (bus.req_ready[id]) ok = 1;
        end
        chk("accept", 32'(ok), 32'd1);
        tick();
        bus.req_valid[id] = 1'b0;
    endtask

    task automatic pulse_done(input logic [7:0] res);
        bus.alu_done   = 1'b1;
        bus.alu_result = res;
        tick();
        bus.alu_done   = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_alu_a"},     32'(bus.alu_a),     32'd0);
        chk({tag, "_alu_b"},     32'(bus.alu_b),     32'd0);
        chk({tag, "_alu_op"},    32'(bus.alu_op),    32'd0);
        chk({tag, "_alu_start"}, 32'(bus.alu_start), 32'd0);
        chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
        chk({tag, "_rsp_id"},    32'(bus.rsp_id),    32'd0);
        chk({tag, "_rsp_data"},  32'(bus.rsp_data),  32'd0);
        chk({tag, "_rsp_err"},   32'(bus.rsp_err),   32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
`ifdef ALU_SCHED_RR_EN
        exp_order = '{0, 1, 0, 1};
`else
        exp_order = '{0, 0, 0, 0};
`endif
        bus.req_valid  = 2'b00;
        bus.req0_a = '0; bus.req0_b = '0; bus.req0_op = '0;
        bus.req1_a = '0; bus.req1_b = '0; bus.req1_op = '0;
        bus.alu_done   = 1'b0;
        bus.alu_result = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        chk("reset_req_ready", 32'(bus.req_ready), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Contention: both requesters held valid for four operations.
        set_req(0, 6'h01, 6'h02, 3'd1);
        set_req(1, 6'h03, 6'h04, 3'd2);
        for (int k = 0; k < 4; k++) begin
            int got;
            int n;
            got = -1;
            n   = 0;
            while (got < 0 && n < 40) begin
                @(negedge clk);
                n++;
                if (bus.req_ready == 2'b01) got = 0;
                else if (bus.req_ready == 2'b10) got = 1;
            end
            chk("grant_order", 32'(got), 32'(exp_order[k]));
            if (got >= 0) begin
                exp_q.push_back('{id: got[0], data: 8'(8'h10 + k), err: 1'b0});
                tick();
                chk("cont_alu_a", 32'(bus.alu_a), (got == 1) ? 32'h03 : 32'h01);
                tick();
                pulse_done(8'(8'h10 + k));
            end
        end
        bus.req_valid = 2'b00;
        repeat (2) tick();

        // Single request with exact timing.
        set_req(0, 6'h2A, 6'h3F, 3'd1);
        wait_accept(0);
        exp_q.push_back('{id: 1'b0, data: 8'h69, err: 1'b0});
        chk("single_alu_start", 32'(bus.alu_start), 32'd1);
        chk("single_alu_a",     32'(bus.alu_a),     32'h2A);
        chk("single_alu_b",     32'(bus.alu_b),     32'h3F);
        chk("single_alu_op",    32'(bus.alu_op),    32'd1);
        tick();
        chk("single_start_pulse", 32'(bus.alu_start), 32'd0);
        tick();
        pulse_done(8'h69);
        chk("single_rsp_latency", 32'(bus.rsp_valid), 32'd1);
        repeat (2) tick();

        // Operand extremes.
        set_req(0, 6'h3F, 6'h00, 3'd7);
        wait_accept(0);
        exp_q.push_back('{id: 1'b0, data: 8'h3F, err: 1'b0});
        chk("ext_alu_a",  32'(bus.alu_a),  32'h3F);
        chk("ext_alu_b",  32'(bus.alu_b),  32'h00);
        chk("ext_alu_op", 32'(bus.alu_op), 32'd7);
        tick();
        pulse_done(8'h3F);
        repeat (2) tick();

        // Done during ISSUE is ignored.
        set_req(0, 6'h07, 6'h09, 3'd3);
        wait_accept(0);
        bus.alu_done   = 1'b1;
        bus.alu_result = 8'hAA;
        tick();
        bus.alu_done   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("issue_done_ignored", 32'(bus.rsp_valid), 32'd0);
        end
        tick();
        exp_q.push_back('{id: 1'b0, data: 8'h05, err: 1'b0});
        pulse_done(8'h05);
        chk("late_done_rsp", 32'(bus.rsp_valid), 32'd1);
        repeat (2) tick();

        // Timeout on requester 1.
        set_req(1, 6'h05, 6'h06, 3'd2);
        wait_accept(1);
        exp_q.push_back('{id: 1'b1, data: 8'hFF, err: 1'b1});
        tick();
        begin
            int n;
            n = 0;
            while (!bus.rsp_valid && n < 40) begin
                tick();
                n++;
            end
            chk("timeout_latency", 32'(n), 32'd16);
        end
        repeat (2) tick();

        // Reset while waiting: no response, late done ignored.
        set_req(1, 6'h11, 6'h22, 3'd4);
        wait_accept(1);
        repeat (2) tick();
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        tick();
        rst_n = 1'b1;
        bus.alu_done   = 1'b1;
        bus.alu_result = 8'h77;
        tick();
        bus.alu_done   = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("midreset_no_rsp", 32'(bus.rsp_valid), 32'd0);
        end

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
